// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the 8-tap low-pass FIR filter.
// Coefficients are symmetric (linear phase) and sum to 32, so the DC gain after the shift is 4.
package fir_pkg;

    localparam int IN_W  = 14;
    localparam int OUT_W = 16;
    localparam int TAPS  = 8;
    localparam int SHIFT = 3;
    localparam int ACC_W = 20;

    typedef logic signed [IN_W-1:0]  sample_t;
    typedef logic signed [OUT_W-1:0] out_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic        [3:0]       coef_t;

    localparam coef_t COEF [0:TAPS-1] = '{4'd1, 4'd3, 4'd4, 4'd8, 4'd8, 4'd4, 4'd3, 4'd1};

    localparam acc_t OUT_MAX = acc_t'(2**(OUT_W-1) - 1);
    localparam acc_t OUT_MIN = acc_t'(-(2**(OUT_W-1)));

    // Floor-scale the accumulator and clamp it into the output range.
    function automatic out_t scaleSaturate(input acc_t acc);
        acc_t y;
        y = acc >>> SHIFT;
        if (y > OUT_MAX) begin
            return out_t'(OUT_MAX);
        end else if (y < OUT_MIN) begin
            return out_t'(OUT_MIN);
        end
        return out_t'(y);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register; taps_o[0] holds the newest sample.
module fir_delay_line
    import fir_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  sample_t sample_i,
    output sample_t taps_o [TAPS]
);

    sample_t taps_q [TAPS];
    sample_t taps_d [TAPS];

    always_comb begin
        taps_d[0] = sample_i;
        for (int k = 1; k < TAPS; k++) begin
            taps_d[k] = taps_q[k-1];
        end
    end

    // Clearing every tap on reset restarts the filter from a zero history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= taps_d[k];
            end
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/top_level.sv
// 8-tap fixed-coefficient low-pass FIR: one 14-bit sample in and one 16-bit sample out per clock.
// The MAC is a single combinational sum into the output register, giving a two-edge latency.
module top_level
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  adc_input,
    output logic signed [OUT_W-1:0] filtered_output
);

    sample_t taps [TAPS];
    acc_t    acc;
    out_t    out_d;
    out_t    out_q;

    fir_delay_line u_delay (
        .clk      (clk),
        .rst      (rst),
        .sample_i (adc_input),
        .taps_o   (taps)
    );

    // A full-scale input sums to 8192*32, which fits in ACC_W bits without overflow.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + acc_t'(taps[k]) * acc_t'(COEF[k]);
        end
        out_d = scaleSaturate(acc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign filtered_output = out_q;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: directed test-plan sequences plus random samples,
// all compared against an arithmetic reference model of the FIR.
module tb_top_level;

    logic               clk;
    logic               rst;
    logic signed [13:0] adc_input;
    logic signed [15:0] filtered_output;

    int errors = 0;
    int checks = 0;
    int hist [8];
    int coef [8] = '{1, 3, 4, 8, 8, 4, 3, 1};
    int expModel = 0;
    int fresh [10];
    int impulse1000 [9] = '{125, 375, 500, 1000, 1000, 500, 375, 125, 0};
    int step1000 [9]    = '{125, 500, 1000, 2000, 3000, 3500, 3875, 4000, 4000};
    int impulsePos [9]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    int impulseNeg [9]  = '{-1, -1, -1, -1, -1, -1, -1, -1, 0};

    top_level dut (
        .clk             (clk),
        .rst             (rst),
        .adc_input       (adc_input),
        .filtered_output (filtered_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: y = floor(sum(c*x)/8), clamped to 16-bit range.
    function automatic int refOut();
        int acc;
        int q;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += coef[k] * hist[k];
        q = acc / 8;
        if (acc < 0 && (acc % 8) != 0) q -= 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic checkOutput(input string tag);
        checks++;
        assert (int'(filtered_output) === expModel)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, filtered_output, expModel);
        end
    endtask

    task automatic checkValue(input string tag, input int expected);
        checks++;
        assert (int'(filtered_output) === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, filtered_output, expected);
        end
    endtask

    // Drive one sample for one edge, advance the model, then check the output against it.
    task automatic applyStimulus(input logic r, input int v, input string tag);
        @(negedge clk);
        rst = r;
        adc_input = 14'(v);
        @(posedge clk);
        if (!r) begin
            expModel = 0;
            for (int k = 0; k < 8; k++) hist[k] = 0;
        end else begin
            expModel = refOut();
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = v;
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b0;
        adc_input = '0;
        for (int k = 0; k < 8; k++) hist[k] = 0;

        applyStimulus(1'b0, 500, "reset_hold0");
        checkValue("reset_zero0", 0);
        applyStimulus(1'b0, 500, "reset_hold1");
        checkValue("reset_zero1", 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 0, "post_reset_idle");
            checkValue("post_reset_zero", 0);
        end

        applyStimulus(1'b1, 1000, "imp1000_capture");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 0, "imp1000");
            checkValue($sformatf("imp1000_%0d", i), impulse1000[i]);
        end

        applyStimulus(1'b0, 0, "clear_a");
        applyStimulus(1'b1, 1000, "step1000_capture");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1000, "step1000");
            checkValue($sformatf("step1000_%0d", i), step1000[i]);
        end

        applyStimulus(1'b0, 0, "clear_b");
        applyStimulus(1'b1, 1, "impPos_capture");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 0, "impPos");
            checkValue($sformatf("impPos_%0d", i), impulsePos[i]);
        end
        applyStimulus(1'b1, -1, "impNeg_capture");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 0, "impNeg");
            checkValue($sformatf("impNeg_%0d", i), impulseNeg[i]);
        end

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, -8192, "fs_neg");
        checkValue("fs_neg_settled", -32768);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8191, "fs_pos");
        checkValue("fs_pos_settled", 32764);

        // Capture a fresh-start response to an alternating sequence for later comparison.
        applyStimulus(1'b0, 0, "clear_c");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 1000 : -1000, "alt_fresh");
            fresh[i] = int'(filtered_output);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i % 2 == 0) ? 1000 : -1000, "alt_pre");
        applyStimulus(1'b0, 1000, "alt_midreset");
        checkValue("alt_midreset_zero", 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 1000 : -1000, "alt_restart");
            checkValue($sformatf("alt_restart_%0d", i), fresh[i]);
        end

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 31) != 0) ? 1'b1 : 1'b0,
                          int'($urandom_range(0, 16383)) - 8192, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
